sync_debounce: RTL
==================

Name: sync_debounce

Overview:
- Input-conditioning stage that sits directly upstream of the team's D flip-flop registers.
- Takes a raw asynchronous, bouncy 1-bit input (switch or external pin) and synchronizes it into the clk domain.
- Filters it so the output changes only after the input has been stable for a programmable number of cycles.
- Emits one-cycle rise/fall pulses, so downstream registers see a clean level and clean edge events.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops; legal values are 2 or more.
- STABLE_CNT, 16: consecutive cycles the synchronized input must differ from q_out before q_out updates; legal values are 1 or more.
- RESET_VAL, 1'b0: reset value of the synchronizer flops and q_out.
- CNT_W, $clog2(STABLE_CNT+1): localparam (derived, not overridable); width of the stability counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- d_in  input  1  raw asynchronous input; may glitch or bounce at any time.
- q_out  output  1  debounced, synchronized level.
- rise_pulse  output  1  high for exactly one cycle when q_out goes 0->1.
- fall_pulse  output  1  high for exactly one cycle when q_out goes 1->0.
- busy  output  1  high while a candidate change is being qualified (FSM in COUNT).

Behaviour:
- Reset (rst_n low):
  - Applies immediately, with no clk edge needed.
  - Sync flops and q_out go to RESET_VAL; rise_pulse, fall_pulse and busy go to 0.
  - FSM goes to STABLE; the counter goes to 0.
- Synchronizer:
  - Chain of SYNC_STAGES flops; stage 0 samples d_in.
  - sync_s is the last stage. No logic other than the chain touches d_in.
- FSM, evaluated every rising edge; the cnt_nxt = cnt + 1 rule applies in both states:
  - STABLE, with sync_s == q_out: stay in STABLE, cnt = 0.
  - STABLE, with sync_s != q_out: if cnt_nxt == STABLE_CNT, commit; otherwise go to COUNT with cnt = cnt_nxt (that is, 1).
  - COUNT, with sync_s == q_out: glitch rejected; go to STABLE, cnt = 0, no pulse.
  - COUNT, with sync_s != q_out and cnt_nxt == STABLE_CNT: commit.
  - COUNT, with sync_s != q_out otherwise: stay in COUNT with cnt = cnt_nxt.
  - Commit: q_out <= sync_s; go to STABLE; cnt = 0.
- Pulses:
  - Registered and set on the same edge that q_out changes; cleared on the next edge.
  - Never both high in the same cycle.
- busy = (state == COUNT), registered.
- Latency: d_in held stable from edge 0 makes q_out change at edge SYNC_STAGES + STABLE_CNT.
  - busy is high for STABLE_CNT - 1 cycles before the commit.
  - With STABLE_CNT = 1, busy never asserts.
- Counter: cnt never exceeds STABLE_CNT - 1 and never wraps.
- Reset release with d_in != RESET_VAL:
  - No pulse on release.
  - The input is then qualified normally, and the pulse appears after the full latency.
- Reset mid-count: the count is aborted and nothing is committed.

Decomposition:
- Shared package seq_common_pkg holds:
  - state encodings ST_STABLE = 1'b0 and ST_COUNT = 1'b1;
  - the clog2 helper function used for CNT_W.
- One natural sub-module, sync_ff_chain (parameter SYNC_STAGES, RESET_VAL; ports clk, rst_n, d_in, q_out).
  - It is a plain chain of D flip-flops with the same asynchronous active-low reset.
  - Instantiated once.

Test Plan (SYNC_STAGES=2, STABLE_CNT=4, RESET_VAL=0 unless noted):
1. Hold rst_n=0 with d_in=1 for 5 cycles -> q_out, rise_pulse, fall_pulse and busy all 0; release rst_n -> rise_pulse high 1 cycle and q_out=1 exactly at edge 6 after release.
2. From q_out=0, step d_in 0->1 and hold -> busy high for edges 3-5; q_out=1 and rise_pulse=1 at edge 6; rise_pulse=0 at edge 7; fall_pulse stays 0.
3. d_in high for 3 cycles, then low -> busy asserts and then returns to 0; q_out stays 0; no pulse ever.
4. d_in toggles every 2 cycles for 20 cycles, then settles at 1 -> exactly one rise_pulse, at edge 6 after the final transition; no fall_pulse.
5. Settled at q_out=1, drop d_in to 0 and hold -> fall_pulse high exactly 1 cycle at edge 6; q_out=0.
6. Assert rst_n=0 between clk edges while busy=1 -> q_out and busy go 0 immediately without an edge; no pulse at any time. Also rerun scenario 2 with STABLE_CNT=1 -> q_out changes at edge 3 and busy never asserts.

Source files
------------

// File: rtl/seq_common_pkg.sv
// Shared FSM state encodings and elaboration-time helpers for the sequential
// input-conditioning blocks.
package seq_common_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } state_t;

  // Bits needed to represent values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Plain D flip-flop synchronizer chain; stage 0 samples the asynchronous input,
// the last stage is the clk-domain output.
module sync_ff_chain #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q_out
);

  logic [SYNC_STAGES-1:0] stg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      stg <= {stg[SYNC_STAGES-2:0], d_in};
    end
  end

  assign q_out = stg[SYNC_STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// Synchronizes and debounces a bouncy asynchronous input; q_out only follows
// the input after it has disagreed with q_out for STABLE_CNT consecutive cycles.
module sync_debounce
  import seq_common_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   STABLE_CNT  = 16,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CNT_W = clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT);

  logic             sync_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_nxt;
  logic             q_d, rise_d, fall_d;

  sync_ff_chain #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (RESET_VAL)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (d_in),
    .q_out(sync_s)
  );

  // cnt stays below STABLE_CNT, so the increment never overflows CNT_W.
  assign cnt_nxt = cnt + CNT_W'(1);

  always_comb begin
    state_nxt = state;
    cnt_d     = cnt;
    q_d       = q_out;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    if (sync_s == q_out) begin
      // Agreement in COUNT means the candidate was a glitch: drop it silently.
      state_nxt = ST_STABLE;
      cnt_d     = '0;
    end else if (cnt_nxt == CNT_LAST) begin
      state_nxt = ST_STABLE;
      cnt_d     = '0;
      q_d       = sync_s;
      rise_d    = sync_s;
      fall_d    = ~sync_s;
    end else begin
      state_nxt = ST_COUNT;
      cnt_d     = cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_STABLE;
      cnt        <= '0;
      q_out      <= RESET_VAL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_d;
      q_out      <= q_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  end

  assign busy = (state == ST_COUNT);

endmodule
